// File: rtl/ray_issue.sv
`default_nettype none
// ============================================================================
// Module   : ray_issue
// Purpose  : Dual-lane camera ray generator. After a start pulse it scans an
//            IMG_W x IMG_H pixel grid, two horizontally adjacent pixels at a
//            time. Each pair becomes one ray in lane 1 and one in lane 2 of
//            the downstream hit-test input FIFOs. All four FIFOs are written
//            together or not at all.
// Ports    : clock         - single clock, rising edge
//            reset         - asynchronous, active-low
//            start         - one-cycle frame request, honoured only in IDLE
//            cam_origin    - camera position (x,y,z) in signed Q, latched on start
//            focal         - z of every direction in signed Q, latched on start
//            in_full       - full flags {dir_2, dir_1, origin_2, origin_1}
//            in_wr_en      - write enables, same bit order as in_full
//            origin_1/2    - ray origins for lane 1 / lane 2
//            dir_1/2       - ray directions for lane 1 / lane 2
//            busy          - high while rays are being issued
//            done          - one-cycle pulse at frame end
//            pixel_x/y     - lane-1 pixel of the pending pair
// Revision : 1.0 - initial release
// ============================================================================
module ray_issue #(
  parameter int Q_BITS = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0][31:0] cam_origin,
  input  logic [31:0]      focal,
  input  logic [3:0]       in_full,
  output logic [3:0]       in_wr_en,
  output logic [2:0][31:0] origin_1,
  output logic [2:0][31:0] origin_2,
  output logic [2:0][31:0] dir_1,
  output logic [2:0][31:0] dir_2,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pixel_x,
  output logic [15:0]      pixel_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] C_LAST_X = 16'(IMG_W - 2);
  localparam logic [15:0] C_LAST_Y = 16'(IMG_H - 1);

  state_t      r_state;
  logic [31:0] r_focal;

  logic        w_write;
  logic        w_row_end;
  logic        w_last;
  logic [15:0] w_next_x;
  logic [15:0] w_next_y;

  // Integer pixel offset to signed Q; wraps silently at 32 bits.
  function automatic logic [31:0] to_q(input int v);
    to_q = 32'(v) << Q_BITS;
  endfunction

  // Direction through pixel (x,y): image centre maps to (0,0), y grows upward.
  function automatic logic [2:0][31:0] make_dir(input int x, input int y,
                                                input logic [31:0] z);
    make_dir[0] = to_q(x - IMG_W / 2);
    make_dir[1] = to_q(IMG_H / 2 - y);
    make_dir[2] = z;
  endfunction

  // A write needs every FIFO to have room, so a single full flag blocks all lanes.
  assign w_write   = (r_state == S_ISSUE) && ~|in_full;
  assign in_wr_en  = w_write ? 4'b1111 : 4'b0000;

  assign w_row_end = (pixel_x == C_LAST_X);
  assign w_last    = w_row_end && (pixel_y == C_LAST_Y);
  assign w_next_x  = w_row_end ? 16'd0 : pixel_x + 16'd2;
  assign w_next_y  = w_row_end ? pixel_y + 16'd1 : pixel_y;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_focal  <= '0;
      origin_1 <= '0;
      origin_2 <= '0;
      dir_1    <= '0;
      dir_2    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pixel_x  <= '0;
      pixel_y  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_focal  <= focal;
            origin_1 <= cam_origin;
            origin_2 <= cam_origin;
            pixel_x  <= '0;
            pixel_y  <= '0;
            dir_1    <= make_dir(0, 0, focal);
            dir_2    <= make_dir(1, 0, focal);
            busy     <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Data for the next pair is produced on the edge that retires the
          // current one, so outputs are always valid while issuing.
          if (w_write) begin
            pixel_x <= w_next_x;
            pixel_y <= w_next_y;
            dir_1   <= make_dir(int'(w_next_x), int'(w_next_y), r_focal);
            dir_2   <= make_dir(int'(w_next_x) + 1, int'(w_next_y), r_focal);
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ray_issue.md
Name: ray_issue

Overview:
Dual-lane camera ray generator that sits on the input side of p_hit. After a start pulse it scans an IMG_W x IMG_H pixel grid. For each pair of horizontally adjacent pixels it writes one ray into lane 1 and one into lane 2 of p_hit's four input FIFOs: origin_1, origin_2, dir_1 and dir_2. It is the writer end of the in_wr_en/in_full interface, and it honours back-pressure.

Parameters:
Q_BITS, 16, fractional bits of the signed Q format; must match p_hit.
IMG_W, 8, image width in pixels; must be even and at least 2.
IMG_H, 8, image height in pixels; must be at least 1.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
cam_origin[2:0]  input  32 each (signed)  camera position in Q; latched on start.
focal  input  32 (signed)  z component of every direction in Q; latched on start.
in_full[3:0]  input  1 each  full flags, in order: origin_1, origin_2, dir_1, dir_2 FIFOs.
in_wr_en[3:0]  output  1 each  write enables, same index order as in_full.
origin_1[2:0], origin_2[2:0]  output  32 each  ray origins, lane 1 and lane 2.
dir_1[2:0], dir_2[2:0]  output  32 each  ray directions, lane 1 and lane 2.
busy  output  1  high while in ISSUE.
done  output  1  one-cycle pulse at frame end.
pixel_x  output  16  lane-1 x of the pending pair.
pixel_y  output  16  y of the pending pair.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state goes to IDLE; all data outputs, pixel_x, pixel_y, busy and done go to 0; in_wr_en goes to 4'b0000.
  - Mid-frame reset abandons the frame; no further writes occur.
- IDLE:
  - in_wr_en = 0.
  - On start=1: latch cam_origin and focal, set pixel_x=0 and pixel_y=0, go to ISSUE.
- ISSUE:
  - in_wr_en is combinational: all four bits equal (~|in_full). Writes are all-or-nothing; no lane is ever written alone.
  - Data outputs are registered and are valid whenever state is ISSUE.
  - Both origins equal the latched cam_origin.
  - dir_1 = ((pixel_x - IMG_W/2) << Q_BITS, (IMG_H/2 - pixel_y) << Q_BITS, focal).
  - dir_2 = ((pixel_x + 1 - IMG_W/2) << Q_BITS, same y as dir_1, focal).
  - Arithmetic is signed 32-bit; results truncate to 32 bits with no saturation.
  - On a write cycle, counters advance:
    - if pixel_x == IMG_W-2: pixel_x = 0 and pixel_y increments;
    - otherwise pixel_x increases by 2.
    - Data outputs update on the same edge.
  - The write with pixel_x == IMG_W-2 and pixel_y == IMG_H-1 is the last write; the state then goes to DONE.
  - Any in_full bit high stalls the block: no write, and counters and data hold stable.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE.
  - A start in DONE is ignored.
- start in ISSUE is ignored.
- Totals and latency:
  - Exactly IMG_W*IMG_H/2 writes per frame.
  - With no back-pressure, the first write is in the cycle after the start edge, and done follows the last write by 1 cycle.
- cam_origin and focal changes after start have no effect until the next frame.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2.
1. Basic frame: cam_origin=(0,0,0xFFFB0000), focal=0x00010000, in_full=0.
   - Write 1: dir_1=(0xFFFE0000, 0x00010000, 0x00010000), dir_2.x=0xFFFF0000.
   - Write 2: dir_1.x=0x00000000, dir_2.x=0x00010000.
   - Writes 3 and 4: y component = 0x00000000.
   - Exactly 4 in_wr_en=4'hF cycles, then done for 1 cycle, then IDLE.
2. Back-pressure: in_full[2]=1 for 3 cycles before write 2.
   - in_wr_en=0 for those 3 cycles; pixel_x stays 2; data is unchanged.
   - Write 2 occurs on the first cycle with in_full=0.
   - Total writes still 4.
3. Single-lane full: in_full=4'b0001 for 1 cycle.
   - in_wr_en=4'b0000 in that cycle; it never shows a partial pattern.
4. Mid-frame reset: drive reset low during write 3.
   - in_wr_en drops to 0 without waiting for a clock edge; busy=0; no done pulse.
   - The next start restarts at (0,0) with dir_1.x=0xFFFE0000.
5. Start ignored: pulse start while busy and again in DONE.
   - Frame still produces 4 writes and one done; no second frame starts.
6. Latch check: change cam_origin to (0x00010000,0,0) after start.
   - All 4 writes still carry origin (0,0,0xFFFB0000).
